// File: rtl/mdu_ctrl_pkg.sv
// Shared types, constants and sign helpers for the multiply/divide sequencer.
// Build option: MDU_FAST_MUL_EN selects the single-cycle multiplier in mdu_ctrl.
package mdu_ctrl_pkg;

  localparam int ITER = 32;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = 6'(ITER - 1);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // Magnitude of an operand; only signed ops with a negative value are negated.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg32_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64_if(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EXE/WB-facing handshake bundle of the multiply/divide sequencer.
interface mdu_ctrl_if;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  modport master (
    output op_valid, op_type, src_a, src_b, cancel, res_ready,
    input  busy, res_valid, res_hi, res_lo
  );

  modport slave (
    input  op_valid, op_type, src_a, src_b, cancel, res_ready,
    output busy, res_valid, res_hi, res_lo
  );
endinterface

// File: rtl/mdu_ctrl_div_radix2.sv
// Restoring divider datapath, one quotient bit per step on unsigned magnitudes.
// The *_nxt outputs are the values after the current step, so the caller can capture the final result on the last step.
module div_radix2 (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quo_nxt_o,
  output logic [31:0] rem_nxt_o
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] shifted_s;
  logic [32:0] diff_s;

  assign shifted_s = {rem_q, quo_q[31]};
  assign diff_s    = shifted_s - {1'b0, dvs_q};

  always_comb begin
    if (!diff_s[32]) begin
      rem_nxt_o = diff_s[31:0];
      quo_nxt_o = {quo_q[30:0], 1'b1};
    end else begin
      rem_nxt_o = shifted_s[31:0];
      quo_nxt_o = {quo_q[30:0], 1'b0};
    end
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (start_i) begin
      rem_d = 32'd0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
    end else if (step_i) begin
      rem_d = rem_nxt_o;
      quo_d = quo_nxt_o;
    end else begin
      rem_d = rem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_q <= 32'd0;
      quo_q <= 32'd0;
      dvs_q <= 32'd0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: FSM, iteration counter, shift-add multiplier, sign fix-up and output registers.
// Build option: MDU_FAST_MUL_EN makes MULT/MULTU complete in one cycle; division always iterates.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  mdu_ctrl_if.slave  bus
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             bzero_q, bzero_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      ma_q, ma_d;
  logic [63:0]      prod_q, prod_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;

  logic        accept_s;
  logic        op_signed_s;
  logic        op_is_div_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic        div_step_s;
  logic [31:0] quo_nxt_s;
  logic [31:0] rem_nxt_s;
  logic [32:0] mul_add_s;
  logic [63:0] mul_nxt_s;
  logic [63:0] mul_res_s;
  logic [31:0] div_hi_s;
  logic [31:0] div_lo_s;
`ifdef MDU_FAST_MUL_EN
  logic [63:0] fast_prod_s;
`endif

  assign accept_s    = (state_q == ST_IDLE) && bus.op_valid && !bus.cancel;
  assign op_signed_s = ~bus.op_type[0];
  assign op_is_div_s = bus.op_type[1];
  assign mag_a_s     = mag32(bus.src_a, op_signed_s);
  assign mag_b_s     = mag32(bus.src_b, op_signed_s);
  assign div_step_s  = (state_q == ST_CALC) && is_div_q && !bus.cancel;

  div_radix2 u_div (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (accept_s && op_is_div_s),
    .step_i     (div_step_s),
    .dividend_i (mag_a_s),
    .divisor_i  (mag_b_s),
    .quo_nxt_o  (quo_nxt_s),
    .rem_nxt_o  (rem_nxt_s)
  );

  // Shift-add step: the multiplier sits in the low half and is consumed LSB first.
  assign mul_add_s = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, ma_q} : 33'd0);
  assign mul_nxt_s = {mul_add_s, prod_q[31:1]};
  assign mul_res_s = neg64_if(mul_nxt_s, neg_res_q);

  // Divide by zero bypasses the sign fix-up so hi/lo match the architectural result exactly.
  assign div_lo_s = bzero_q ? 32'hFFFF_FFFF : neg32_if(quo_nxt_s, neg_res_q);
  assign div_hi_s = bzero_q ? a_q : neg32_if(rem_nxt_s, neg_rem_q);

`ifdef MDU_FAST_MUL_EN
  assign fast_prod_s = neg64_if({32'd0, mag_a_s} * {32'd0, mag_b_s},
                                op_signed_s && (bus.src_a[31] ^ bus.src_b[31]));
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    a_d       = a_q;
    ma_d      = ma_q;
    prod_d    = prod_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          cnt_d     = {CNT_W{1'b0}};
          is_div_d  = op_is_div_s;
          neg_res_d = op_signed_s && (bus.src_a[31] ^ bus.src_b[31]);
          neg_rem_d = op_signed_s && bus.src_a[31];
          bzero_d   = (bus.src_b == 32'd0);
          a_d       = bus.src_a;
          ma_d      = mag_a_s;
          prod_d    = {32'd0, mag_b_s};
`ifdef MDU_FAST_MUL_EN
          if (!op_is_div_s) begin
            state_d  = ST_DONE;
            res_hi_d = fast_prod_s[63:32];
            res_lo_d = fast_prod_s[31:0];
          end else begin
            state_d = ST_CALC;
          end
`else
          state_d = ST_CALC;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (!is_div_q) begin
          prod_d = mul_nxt_s;
        end else begin
          prod_d = prod_q;
        end
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          if (is_div_q) begin
            res_hi_d = div_hi_s;
            res_lo_d = div_lo_s;
          end else begin
            res_hi_d = mul_res_s[63:32];
            res_lo_d = mul_res_s[31:0];
          end
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    // Cancel overrides everything and discards whatever was in flight.
    if (bus.cancel) begin
      state_d  = ST_IDLE;
      cnt_d    = {CNT_W{1'b0}};
      res_hi_d = 32'd0;
      res_lo_d = 32'd0;
    end else begin
      cnt_d = cnt_d;
    end

    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      bzero_q     <= 1'b0;
      a_q         <= 32'd0;
      ma_q        <= 32'd0;
      prod_q      <= 64'd0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_hi_q    <= 32'd0;
      res_lo_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      bzero_q     <= bzero_d;
      a_q         <= a_d;
      ma_q        <= ma_d;
      prod_q      <= prod_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.res_lo    = res_lo_q;

endmodule
